pwm_multichannel: RTL and testbench
===================================

# pwm_multichannel

Parametrised multi-channel PWM generator, the next generation of the 16-output onboarding PWM peripheral. It adds:
- a configurable channel count and counter width;
- a clock prescaler and a programmable period;
- per-channel double-buffered duty registers that update glitch-free at period boundaries.

It sits between the SPI-fed register file and the top-level `uo_out`/`uio_out` pins.

## Interface
- `NUM_CH`, 16: number of PWM channels (1..32).
- `CNT_W`, 8: counter, period and duty width.
- `PRESC_W`, 8: prescaler width.
- `CH_W`, `$clog2(NUM_CH)` (min 1): channel index width, derived.

- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `en_out` in NUM_CH: per-channel output enable; 0 forces output low.
- `en_pwm` in NUM_CH: per-channel PWM enable; 0 with `en_out`=1 drives a static high.
- `duty_wr` in 1: write strobe for the duty shadow register.
- `duty_ch` in CH_W: target channel of `duty_wr`.
- `duty_val` in CNT_W: duty value.
- `period_wr` in 1: write strobe for the period shadow register.
- `period_val` in CNT_W: period value P; the counter runs 0..P.
- `presc` in PRESC_W: prescale divisor minus 1; the counter advances every `presc`+1 cycles.
- `restart` in 1: synchronous counter restart.
- `out` out NUM_CH: registered PWM outputs.
- `period_start` out 1: one-cycle pulse marking the first output cycle of each period.

## Operation
- **Prescaler** `pc`:
  - counts 0..`presc`; `tick` = (`pc`==`presc`); wraps to 0 on `tick`.
  - `presc` is live, not shadowed. If `presc` is lowered below `pc`, `pc` counts on and wraps at its all-ones value, then resumes normal operation.
- **Main counter** `cnt`:
  - on `tick`, `cnt`==P_act → 0 (wrap), else `cnt`+1.
  - P_act=0 gives a constant `cnt`=0 with a wrap on every tick.
- **Shadows**: `duty_wr` writes `duty_sh[duty_ch]`; `period_wr` writes `P_sh`. A `duty_ch` ≥ NUM_CH is ignored.
- **Load event** (wrap or `restart`): `duty_act[i]` ← `duty_sh[i]` and P_act ← `P_sh`.
  - The load uses the shadow values held before that edge.
  - A write in the same cycle lands in the shadow and takes effect at the next load event.
- **`restart`**: `pc` ← 0, `cnt` ← 0, load event. It has priority over `tick`.
- **Channel i, next output value**:
  - `!en_out[i]` → 0.
  - else `!en_pwm[i]` → 1.
  - else `duty_act[i]`==all-ones or `duty_act[i]` > P_act → 1 (legacy 100 % code).
  - else (`cnt` < `duty_act[i]`).
- Duty 0 → constant low. High time is D·(`presc`+1) cycles per period of (P+1)·(`presc`+1) cycles.
- **`period_start`**: registered; asserted for 1 cycle when the registered `cnt` value driving `out` is 0 following a load event. It does not assert at reset exit.

## Timing
- **Reset** (`rst_n`=0 at an edge):
  - `pc`=0, `cnt`=0, `out`=0, `period_start`=0.
  - all `duty_sh`/`duty_act`=0; `P_sh`=P_act=all-ones (matches 8-bit legacy: 256-step period).
- **Reset mid-period**: takes effect at the next edge and overrides `restart`, writes and `tick`.
- **Latency**:
  - `out` reflects `cnt`/`duty_act`/`en_*` sampled at the previous edge: 1 cycle.
  - A change of `en_out`/`en_pwm` is visible on `out` 1 cycle later.
- **Duty/period update**: never mid-period. The first period using new values starts with the `out` cycle flagged by `period_start`.
- `tick`, wrap, load and write may coincide; the ordering is as defined above.

## Structure
- **Package `pwm_pkg`**:
  - reset constants (`PWM_DUTY_RST`, `PWM_PERIOD_RST` as all-ones of CNT_W);
  - the legacy full-duty code;
  - the `pwm_ch_cfg_t` struct {`en_out`, `en_pwm`, duty}.
- **Sub-module `pwm_channel`**:
  - holds one `duty_sh`/`duty_act` pair, the compare logic and the output flop;
  - instantiated NUM_CH times in a generate loop.
- The top level holds the prescaler, counter, period shadow, write decode and `period_start`.

## Test plan
- **Reset defaults**: reset, `presc`=0, all enables 1, no writes → `out`=0 constantly (duty 0); P_act=255, `period_start` every 256 cycles after the first wrap.
- **Basic duty**: `presc`=0, `period_wr` P=9, `duty_wr` ch3=4, then `restart` → `out[3]` high 4 / low 6 cycles, repeating; `period_start` every 10 cycles, coincident with `out[3]` rising.
- **Prescaler**: `presc`=3, P=9, ch0 duty=5 → high 20 / low 20 cycles.
- **Mid-period write**: in the same setup, write ch3=7 at `cnt`=2 → current period keeps 4 high; the next period is 7 high, 3 low.
- **Boundaries and enables**:
  - P=9, duty 0 → constant 0; duty 10 → constant 1; duty 255 → constant 1.
  - `en_out`=0 → 0; `en_out`=1, `en_pwm`=0 → 1; each change visible 1 cycle later.
- **Collisions and addressing**:
  - `duty_wr` in the wrap cycle → new value applies one period later.
  - `duty_ch`=NUM_CH (NUM_CH=12 build) → no channel changes.
  - reset asserted mid-period → all outputs 0 next cycle.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, per-channel config struct and the output
// compare function for the multi-channel PWM generator.
//   PWM_MAX_W      - widest counter/duty supported (CNT_W must not exceed it)
//   PWM_DUTY_RST   - duty register reset value (zero, i.e. output low)
//   PWM_PERIOD_RST - period register reset value (all-ones, full-range period)
//   pwm_ch_cfg_t   - {en_out, en_pwm, duty} as seen by the compare function
//   pwm_full_code  - legacy 100 % duty code (all-ones of a given width)
//   pwm_next_out   - next value of one channel output
package pwm_pkg;

    localparam int PWM_MAX_W = 32;

    localparam logic [PWM_MAX_W-1:0] PWM_DUTY_RST   = '0;
    localparam logic [PWM_MAX_W-1:0] PWM_PERIOD_RST = '1;

    typedef struct packed {
        logic                 en_out;
        logic                 en_pwm;
        logic [PWM_MAX_W-1:0] duty;
    } pwm_ch_cfg_t;

    // All-ones of 'width' bits, zero-extended to PWM_MAX_W.
    function automatic logic [PWM_MAX_W-1:0] pwm_full_code(input int width);
        logic [PWM_MAX_W-1:0] code;
        code = '0;
        for (int b = 0; b < PWM_MAX_W; b++) begin
            if (b < width) begin
                code[b] = 1'b1;
            end
        end
        return code;
    endfunction

    // Values are zero-extended to PWM_MAX_W so the compare is width-agnostic.
    // A duty above the period, or the legacy all-ones code, means 100 %.
    function automatic logic pwm_next_out(
        input pwm_ch_cfg_t          cfg,
        input logic [PWM_MAX_W-1:0] cnt,
        input logic [PWM_MAX_W-1:0] period,
        input logic [PWM_MAX_W-1:0] full_code
    );
        logic result;
        if (!cfg.en_out) begin
            result = 1'b0;
        end else if (!cfg.en_pwm) begin
            result = 1'b1;
        end else if ((cfg.duty == full_code) || (cfg.duty > period)) begin
            result = 1'b1;
        end else begin
            result = (cnt < cfg.duty);
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output. Holds the duty shadow register, the active
// duty register (reloaded only on a load event) and the registered output.
//   clk, rst_n - clock, synchronous active-low reset
//   wr_en      - write wr_val into the duty shadow
//   wr_val     - duty value to write
//   load       - period boundary or restart: shadow -> active
//   en_out     - 0 forces the output low
//   en_pwm     - 0 (with en_out=1) forces the output high
//   cnt, p_act - shared main counter and active period
//   out        - registered PWM output
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_val,
    input  logic             load,
    input  logic             en_out,
    input  logic             en_pwm,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] p_act,
    output logic             out
);

    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             out_q, out_d;
    pwm_ch_cfg_t      cfg;

    always_comb begin
        duty_sh_d  = wr_en ? wr_val : duty_sh_q;
        // Load takes the shadow as it stood before this edge; a write in the
        // same cycle waits for the next load.
        duty_act_d = load ? duty_sh_q : duty_act_q;

        cfg.en_out = en_out;
        cfg.en_pwm = en_pwm;
        cfg.duty   = PWM_MAX_W'(duty_act_q);
        out_d      = pwm_next_out(cfg, PWM_MAX_W'(cnt), PWM_MAX_W'(p_act),
                                  pwm_full_code(CNT_W));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_sh_q  <= CNT_W'(PWM_DUTY_RST);
            duty_act_q <= CNT_W'(PWM_DUTY_RST);
            out_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            out_q      <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: NUM_CH-channel PWM generator with a shared prescaler,
// main counter and double-buffered period/duty registers.
//   clk, rst_n   - clock, synchronous active-low reset
//   en_out       - per-channel output enable (0 -> output low)
//   en_pwm       - per-channel PWM enable (0 with en_out=1 -> output high)
//   duty_wr      - duty shadow write strobe, target duty_ch, value duty_val
//   period_wr    - period shadow write strobe, value period_val (cnt runs 0..P)
//   presc        - prescale divisor minus 1 (live, not shadowed)
//   restart      - clear prescaler and counter, force a load event
//   out          - registered PWM outputs
//   period_start - one-cycle pulse on the first output cycle of each period
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic               duty_wr,
    input  logic [CH_W-1:0]    duty_ch,
    input  logic [CNT_W-1:0]   duty_val,
    input  logic               period_wr,
    input  logic [CNT_W-1:0]   period_val,
    input  logic [PRESC_W-1:0] presc,
    input  logic               restart,
    output logic [NUM_CH-1:0]  out,
    output logic               period_start
);

    logic [PRESC_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   p_sh_q, p_sh_d;
    logic [CNT_W-1:0]   p_act_q, p_act_d;
    logic               load_dly_q, load_dly_d;
    logic               period_start_q, period_start_d;
    logic               tick;
    logic               wrap;
    logic               load;

    always_comb begin
        tick = (pc_q == presc);
        wrap = tick && (cnt_q == p_act_q);
        load = wrap || restart;

        // If presc drops below pc, pc simply keeps counting and wraps at
        // all-ones through natural overflow.
        if (restart || tick) begin
            pc_d = '0;
        end else begin
            pc_d = pc_q + 1'b1;
        end

        if (restart || wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        p_sh_d  = period_wr ? period_val : p_sh_q;
        p_act_d = load ? p_sh_q : p_act_q;

        // cnt is 0 right after a load; the output built from that value
        // appears one edge later, so the pulse is the load delayed twice.
        load_dly_d     = load;
        period_start_d = load_dly_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q           <= '0;
            cnt_q          <= '0;
            p_sh_q         <= CNT_W'(PWM_PERIOD_RST);
            p_act_q        <= CNT_W'(PWM_PERIOD_RST);
            load_dly_q     <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            cnt_q          <= cnt_d;
            p_sh_q         <= p_sh_d;
            p_act_q        <= p_act_d;
            load_dly_q     <= load_dly_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    // Out-of-range duty_ch values match no channel and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;
        assign wr_en = duty_wr && (duty_ch == CH_W'(i));

        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_en  (wr_en),
            .wr_val (duty_val),
            .load   (load),
            .en_out (en_out[i]),
            .en_pwm (en_pwm[i]),
            .cnt    (cnt_q),
            .p_act  (p_act_q),
            .out    (out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
module tb_pwm_multichannel;
    localparam int NUM_CH  = 12;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 8;
    localparam int CH_W    = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_CH-1:0]  en_out;
    logic [NUM_CH-1:0]  en_pwm;
    logic               duty_wr;
    logic [CH_W-1:0]    duty_ch;
    logic [CNT_W-1:0]   duty_val;
    logic               period_wr;
    logic [CNT_W-1:0]   period_val;
    logic [PRESC_W-1:0] presc;
    logic               restart;
    logic [NUM_CH-1:0]  out;
    logic               period_start;

    int checks   = 0;
    int failures = 0;

    pwm_multichannel #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W),
        .CH_W    (CH_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .duty_wr      (duty_wr),
        .duty_ch      (duty_ch),
        .duty_val     (duty_val),
        .period_wr    (period_wr),
        .period_val   (period_val),
        .presc        (presc),
        .restart      (restart),
        .out          (out),
        .period_start (period_start)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic write_duty(input int ch, input int val);
        duty_wr  = 1'b1;
        duty_ch  = CH_W'(ch);
        duty_val = CNT_W'(val);
        cyc();
        duty_wr  = 1'b0;
    endtask

    task automatic write_period(input int val);
        period_wr  = 1'b1;
        period_val = CNT_W'(val);
        cyc();
        period_wr  = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset();
        logic exp_ps;
        rst_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cyc();
            checks++;
            if (out !== '0 || period_start !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold out=%h ps=%b expected out=0 ps=0", out, period_start);
            end
        end
        rst_n = 1'b1;
        // P=255 after reset: first wrap on edge 256, pulse visible after edge 257.
        for (int n = 1; n <= 600; n++) begin
            cyc();
            exp_ps = (n == 257) || (n == 513);
            checks++;
            if (out !== '0 || period_start !== exp_ps) begin
                failures++;
                $display("FAIL reset_default n=%0d out=%h ps=%b expected out=0 ps=%b",
                         n, out, period_start, exp_ps);
            end
        end
    endtask

    task automatic test_basic_duty();
        logic [NUM_CH-1:0] exp;
        int pos;
        presc = '0;
        write_period(9);
        write_duty(3, 4);
        do_restart();
        for (int n = 1; n <= 30; n++) begin
            cyc();
            pos = (n - 1) % 10;
            exp = '0;
            exp[3] = (pos < 4);
            checks++;
            if (out !== exp || period_start !== (pos == 0)) begin
                failures++;
                $display("FAIL basic_duty n=%0d out=%h ps=%b expected out=%h ps=%b",
                         n, out, period_start, exp, (pos == 0));
            end
        end
    endtask

    task automatic test_prescaler();
        logic [NUM_CH-1:0] exp;
        int pos;
        write_duty(0, 5);
        presc = 8'd3;
        do_restart();
        for (int n = 1; n <= 80; n++) begin
            cyc();
            pos = (n - 1) % 40;
            exp = '0;
            exp[0] = (pos < 20);
            exp[3] = (pos < 16);
            checks++;
            if (out !== exp || period_start !== (pos == 0)) begin
                failures++;
                $display("FAIL prescaler n=%0d out=%h ps=%b expected out=%h ps=%b",
                         n, out, period_start, exp, (pos == 0));
            end
        end
    endtask

    task automatic test_mid_period_write();
        logic [NUM_CH-1:0] exp;
        int pos;
        int hi3;
        presc = '0;
        do_restart();
        for (int n = 1; n <= 30; n++) begin
            cyc();
            pos = (n - 1) % 10;
            hi3 = (n <= 10) ? 4 : 7;
            exp = '0;
            exp[0] = (pos < 5);
            exp[3] = (pos < hi3);
            checks++;
            if (out !== exp) begin
                failures++;
                $display("FAIL mid_write n=%0d out=%h expected %h", n, out, exp);
            end
            if (n == 2) begin
                duty_wr  = 1'b1;
                duty_ch  = 4'd3;
                duty_val = 8'd7;
            end else if (n == 3) begin
                duty_wr  = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NUM_CH-1:0] exp;
        int pos;
        int hi3;
        do_restart();
        for (int n = 1; n <= 30; n++) begin
            cyc();
            pos = (n - 1) % 10;
            hi3 = (n <= 20) ? 7 : 2;
            exp = '0;
            exp[0] = (pos < 5);
            exp[3] = (pos < hi3);
            checks++;
            if (out !== exp || period_start !== (pos == 0)) begin
                failures++;
                $display("FAIL wrap_write n=%0d out=%h ps=%b expected out=%h ps=%b",
                         n, out, period_start, exp, (pos == 0));
            end
            // This write lands on the wrap edge itself.
            if (n == 9) begin
                duty_wr  = 1'b1;
                duty_ch  = 4'd3;
                duty_val = 8'd2;
            end else if (n == 10) begin
                duty_wr  = 1'b0;
            end
        end
    endtask

    task automatic test_boundaries();
        write_duty(2, 10);
        write_duty(4, 255);
        do_restart();
        for (int n = 1; n <= 20; n++) begin
            cyc();
            checks++;
            if (out[1] !== 1'b0 || out[2] !== 1'b1 || out[4] !== 1'b1) begin
                failures++;
                $display("FAIL duty_bounds n=%0d out[1]=%b out[2]=%b out[4]=%b expected 0 1 1",
                         n, out[1], out[2], out[4]);
            end
        end
    endtask

    task automatic test_enables();
        en_out[2] = 1'b0;
        checks++;
        if (out[2] !== 1'b1) begin
            failures++;
            $display("FAIL en_out_latency out[2]=%b expected 1", out[2]);
        end
        cyc();
        checks++;
        if (out[2] !== 1'b0) begin
            failures++;
            $display("FAIL en_out_off out[2]=%b expected 0", out[2]);
        end
        en_out[2] = 1'b1;
        en_pwm[1] = 1'b0;
        cyc();
        checks++;
        if (out[1] !== 1'b1 || out[2] !== 1'b1) begin
            failures++;
            $display("FAIL en_pwm_off out[1]=%b out[2]=%b expected 1 1", out[1], out[2]);
        end
        en_pwm[1] = 1'b1;
        cyc();
        checks++;
        if (out[1] !== 1'b0) begin
            failures++;
            $display("FAIL en_pwm_on out[1]=%b expected 0", out[1]);
        end
    endtask

    task automatic test_bad_channel();
        logic [NUM_CH-1:0] exp;
        int pos;
        write_duty(NUM_CH, 3);
        do_restart();
        for (int n = 1; n <= 10; n++) begin
            cyc();
            pos = (n - 1) % 10;
            exp = '0;
            exp[0] = (pos < 5);
            exp[2] = 1'b1;
            exp[3] = (pos < 2);
            exp[4] = 1'b1;
            checks++;
            if (out !== exp) begin
                failures++;
                $display("FAIL bad_channel n=%0d out=%h expected %h", n, out, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 3; n++) begin
            cyc();
        end
        rst_n    = 1'b0;
        restart  = 1'b1;
        duty_wr  = 1'b1;
        duty_ch  = 4'd0;
        duty_val = 8'd9;
        cyc();
        checks++;
        if (out !== '0 || period_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid out=%h ps=%b expected out=0 ps=0", out, period_start);
        end
        rst_n   = 1'b1;
        restart = 1'b0;
        duty_wr = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            checks++;
            if (out !== '0 || period_start !== 1'b0) begin
                failures++;
                $display("FAIL reset_after n=%0d out=%h ps=%b expected out=0 ps=0",
                         n, out, period_start);
            end
        end
        do_restart();
        for (int n = 1; n <= 5; n++) begin
            cyc();
            checks++;
            if (out !== '0 || period_start !== (n == 1)) begin
                failures++;
                $display("FAIL reset_cleared n=%0d out=%h ps=%b expected out=0 ps=%b",
                         n, out, period_start, (n == 1));
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        en_out     = '1;
        en_pwm     = '1;
        duty_wr    = 1'b0;
        duty_ch    = '0;
        duty_val   = '0;
        period_wr  = 1'b0;
        period_val = '0;
        presc      = '0;
        restart    = 1'b0;
        #1;

        test_reset();
        test_basic_duty();
        test_prescaler();
        test_mid_period_write();
        test_back_to_back();
        test_boundaries();
        test_enables();
        test_bad_channel();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
